// File: rtl/dm_loader.sv
// dm_loader: byte-stream loader/dumper that owns the data-memory port between runs,
// filling memory from a valid/ready input stream or draining it to a valid/ready output stream.
module dm_loader #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_dat_out,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DUMP_RD, S_DUMP_OUT, S_DONE} state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_rem;
    logic [DW-1:0] r_out_data;
    logic [AW:0]   w_len;
    logic          w_last;
    logic          w_step;

    assign w_len  = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_last = r_rem == (AW+1)'(1);
    // One byte retires per accepted input or accepted output handshake
    assign w_step = (r_state == S_LOAD && in_valid) || (r_state == S_DUMP_OUT && out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = (w_len == '0) ? S_DONE : (mode ? S_DUMP_RD : S_LOAD);
            S_LOAD:     if (in_valid && w_last) w_next = S_DONE;
            S_DUMP_RD:  w_next = S_DUMP_OUT;
            S_DUMP_OUT: if (out_ready) w_next = w_last ? S_DONE : S_DUMP_RD;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_rem      <= '0;
            r_out_data <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_ptr <= base_addr;
                r_rem <= w_len;
            end else if (w_step) begin
                r_ptr <= r_ptr + AW'(1);
                r_rem <= r_rem - (AW+1)'(1);
            end
            if (r_state == S_DUMP_RD) r_out_data <= mem_dat_out;
        end
    end

    assign in_ready   = r_state == S_LOAD;
    assign out_valid  = r_state == S_DUMP_OUT;
    assign out_data   = r_out_data;
    assign mem_write  = (r_state == S_LOAD) && in_valid;
    assign mem_read   = r_state == S_DUMP_RD;
    assign mem_addr   = (r_state == S_LOAD || r_state == S_DUMP_RD) ? r_ptr : '0;
    assign mem_dat_in = (r_state == S_LOAD) ? in_data : '0;
    assign busy       = r_state != S_IDLE;
    assign done       = r_state == S_DONE;
endmodule

// File: tb/tb_dm_loader.sv
// tb_dm_loader: table-driven transfers against a behavioural 256-byte memory, with
// scoreboard queues for expected writes and expected output bytes.
module tb_dm_loader;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] length = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_dat_in;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_dat_out;
    logic       busy;
    logic       done;

    dm_loader #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_write(mem_write),
        .mem_read(mem_read), .mem_dat_out(mem_dat_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_dat_in;
    // Junk value when not enabled, so a capture at the wrong time is visible
    assign mem_dat_out = mem_read ? mem[mem_addr] : 8'hEE;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    logic [15:0] wr_q [$];
    logic [7:0]  out_q [$];
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (mem_write && mem_read) flag("wr_and_rd");
            if (mem_read && out_valid) flag("rd_in_dump_out");
            if ((!busy || done) && (mem_write || mem_read)) flag("mem_access_idle_done");
            if (mem_write) begin
                wr_cnt++;
                if (wr_q.size() == 0) flag("unexpected_write");
                else begin
                    logic [15:0] e;
                    e = wr_q.pop_front();
                    check("wr_addr", mem_addr, e[15:8]);
                    check("wr_data", mem_dat_in, e[7:0]);
                end
            end
            if (mem_read) rd_cnt++;
            if (out_valid && prev_hold) check("out_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) flag("unexpected_output");
                else check("out_data", out_data, out_q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dat(input logic [7:0] seed, input logic [7:0] a, input int i);
        logic [7:0] k;
        k = 8'(i);
        return (seed == 8'h00) ? (a ^ 8'h5A) : 8'(seed + 8'h11 * k);
    endfunction

    // vpat: 0 = always valid/ready, 1 = valid toggles 1,0,1.., 2 = random, 3 = poke start mid-transfer
    typedef struct {
        logic       mode;
        logic [7:0] base;
        logic [8:0] len;
        int         vpat;
        logic [7:0] seed;
        int         n;
    } vec_t;

    task automatic run_xfer(input vec_t v);
        int idx;
        int g;
        logic [7:0] a;
        wr_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < v.n; i++) begin
            a = v.base + 8'(i);
            if (v.mode) out_q.push_back(ref_mem[a]);
            else begin
                wr_q.push_back({a, dat(v.seed, a, i)});
                ref_mem[a] = dat(v.seed, a, i);
            end
        end
        mode = v.mode; base_addr = v.base; length = v.len; start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (v.n == 0) check("done_len0", done, 1);
        else if (v.mode) begin
            check("dump_first_ov", out_valid, 0);
            check("dump_first_rd", mem_read, 1);
        end
        idx = 0;
        g = 0;
        while (v.n > 0 && idx < v.n && g < 4000) begin
            start     = (v.vpat == 3 && g == 1);
            mode      = start ? ~v.mode : v.mode;
            base_addr = start ? 8'h90 : v.base;
            length    = start ? 9'd2 : v.len;
            if (v.mode) begin
                out_ready = (v.vpat == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (out_valid && out_ready) idx++;
            end else begin
                a = v.base + 8'(idx);
                in_valid = (v.vpat == 1) ? (g % 2 == 0) : (v.vpat == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data  = in_valid ? dat(v.seed, a, idx) : ~dat(v.seed, a, idx);
                if (in_valid && in_ready) idx++;
            end
            tick;
            g++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (g >= 4000) flag("xfer_timeout");
        if (v.n > 0) check("done_after_last", done, 1);
        check("wr_count", wr_cnt, v.mode ? 0 : v.n);
        check("rd_count", rd_cnt, v.mode ? v.n : 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("out_q_empty", out_q.size(), 0);
        wr_q.delete();
        out_q.delete();
        tick;
        check("busy_end", busy, 0);
        check("done_end", done, 0);
    endtask

    vec_t tbl[12];
    vec_t fresh;

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 9'h100, 0, 8'h00, 256};
        tbl[1]  = '{1'b0, 8'h10, 9'd4,   0, 8'hA1, 4};
        tbl[2]  = '{1'b0, 8'hFE, 9'd3,   1, 8'h33, 3};
        tbl[3]  = '{1'b1, 8'h80, 9'h100, 2, 8'h00, 256};
        tbl[4]  = '{1'b0, 8'h20, 9'd0,   0, 8'h12, 0};
        tbl[5]  = '{1'b1, 8'h40, 9'd0,   0, 8'h00, 0};
        tbl[6]  = '{1'b0, 8'h40, 9'h1FF, 2, 8'h07, 256};
        tbl[7]  = '{1'b1, 8'hC0, 9'h1FF, 0, 8'h00, 256};
        tbl[8]  = '{1'b1, 8'h20, 9'd3,   3, 8'h00, 3};
        tbl[9]  = '{1'b0, 8'h60, 9'd4,   3, 8'h5C, 4};
        tbl[10] = '{1'b0, 8'h70, 9'd1,   0, 8'h99, 1};
        tbl[11] = '{1'b1, 8'hFF, 9'd2,   0, 8'h00, 2};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) tick;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        tick;
        for (int i = 0; i < 12; i++) run_xfer(tbl[i]);

        // Abort a 5-byte load after two bytes have been written
        wr_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            wr_q.push_back({8'h30 + 8'(i), dat(8'h01, 8'h30 + 8'(i), i)});
            ref_mem[8'h30 + 8'(i)] = dat(8'h01, 8'h30 + 8'(i), i);
        end
        mode = 1'b0; base_addr = 8'h30; length = 9'd5; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = dat(8'h01, 8'h30 + 8'(i), i);
            tick;
        end
        in_data = dat(8'h01, 8'h32, 2);
        #1;
        check("abort_pre_write", mem_write, 1);
        reset_n = 1'b0;
        #1;
        check("abort_mem_write", mem_write, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_data", out_data, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_done", done, 0);
        in_valid = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        check("abort_wr_count", wr_cnt, 2);
        check("abort_wr_q", wr_q.size(), 0);
        tick;
        fresh = '{1'b0, 8'h50, 9'd2, 0, 8'h44, 2};
        run_xfer(fresh);

        for (int i = 0; i < 256; i++) check($sformatf("mem_%02h", i), mem[i], ref_mem[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
